// File: rtl/ifetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package ifetch_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] pc;
    logic [DATA_WIDTH_DEF-1:0] instr;
  } fetch_out_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: PC handshake, instruction-memory bus and decode-side output.
// master = fetch stage, slave = surrounding PC / memory / decode.
interface instruction_fetch_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  fetch_en_i;
  logic [ADDR_WIDTH-1:0] pc_i;
  logic                  pc_advance_o;
  logic                  flush_i;
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_instr_o;
  logic [ADDR_WIDTH-1:0] out_pc_o;
  logic [31:0]           stall_cycles_o;

  modport master (
    input  fetch_en_i, pc_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
    output pc_advance_o, mem_req_o, mem_addr_o, out_valid_o, out_instr_o, out_pc_o,
           stall_cycles_o
  );

  modport slave (
    output fetch_en_i, pc_i, flush_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, out_ready_i,
    input  pc_advance_o, mem_req_o, mem_addr_o, out_valid_o, out_instr_o, out_pc_o,
           stall_cycles_o
  );

endinterface

// File: rtl/ifetch_out_reg.sv
// One-entry valid/ready register holding the {pc, instr} pair presented to decode.
module ifetch_out_reg #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  ready_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] instr_o
);

  // Flush wins over a load; payload is only rewritten on a load so it stays stable while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      instr_o <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      instr_o <= instr_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding req/gnt/rvalid reads, flush-aware response dropping.
// Optional stall counter enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic                 clk_i,
  input logic                 rst_i,
  instruction_fetch_if.master bus
);

  fetch_state_e          state_q;
  logic                  drop_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  load;
  logic                  reg_free_next;
  logic                  start_ok;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;

  assign bus.pc_advance_o = (state_q == REQ) && bus.mem_gnt_i && !drop_q && !bus.flush_i;

  assign load = (state_q == WAIT) && bus.mem_rvalid_i && !drop_q && !bus.flush_i;

  // A new request is only issued once the output register is guaranteed empty,
  // so a returning response can never overwrite an unconsumed instruction.
  assign reg_free_next = !load && (!out_valid || bus.out_ready_i || bus.flush_i);

  // During a flush pc_i still shows the old PC; the target is captured a cycle later.
  assign start_ok = bus.fetch_en_i && !bus.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            addr_q  <= bus.pc_i;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.flush_i) drop_q <= 1'b1;
          if (bus.mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid_i) begin
            drop_q <= 1'b0;
            if (reg_free_next) begin
              if (start_ok) begin
                addr_q  <= bus.pc_i;
                req_q   <= 1'b1;
                state_q <= REQ;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              state_q <= HOLD;
            end
          end else if (bus.flush_i) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: begin
          if (reg_free_next) begin
            if (start_ok) begin
              addr_q  <= bus.pc_i;
              req_q   <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o  = req_q;
  assign bus.mem_addr_o = addr_q;

  ifetch_out_reg #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .flush_i (bus.flush_i),
    .ready_i (bus.out_ready_i),
    .pc_i    (addr_q),
    .instr_i (bus.mem_rdata_i),
    .valid_o (out_valid),
    .pc_o    (out_pc),
    .instr_o (out_instr)
  );

  assign bus.out_valid_o = out_valid;
  assign bus.out_pc_o    = out_pc;
  assign bus.out_instr_o = out_instr;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_q;
  logic        stall_evt;

  assign stall_evt = ((state_q == REQ) && !bus.mem_gnt_i) ||
                     ((state_q == WAIT) && !bus.mem_rvalid_i);

  // Saturating count of cycles spent waiting on the memory.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall_evt && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles_o = stall_q;
`else
  assign bus.stall_cycles_o = '0;
`endif

endmodule
